cpu_prefetch_queue: RTL and testbench

CPU_PREFETCH_QUEUE -- requirements
Module: cpu_prefetch_queue

---
 rtl/cpu_defines_pkg.sv | 17 +
 rtl/cpu_fifo.sv | 53 +++++
 rtl/cpu_prefetch_queue.sv | 135 +++++++++++++
 tb/tb_cpu_prefetch_queue.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defines_pkg.sv
// Shared CPU definitions: prefetch queue entry layout, reset vector and address helpers.
package cpu_defines_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/cpu_fifo.sv
// Circular FIFO with push/pop/flush; head entry is presented combinationally from storage.
module cpu_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  always_ff @(posedge clock) begin
    if (push) storage[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_data = storage[rd_ptr];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/cpu_prefetch_queue.sv
// Instruction prefetch queue: sequential fetch over a single-outstanding bus, with jump/irq redirect.
// state   | meaning
// IDLE    | no bus request outstanding
// REQUEST | request outstanding, response goes into the queue
// DISCARD | request outstanding, response is stale and dropped
module cpu_prefetch_queue
  import cpu_defines_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_jump,
  input  logic [31:0] i_jump_pc,
  input  logic        i_irq_pending,
  input  logic [31:0] i_irq_pc,
  output logic        o_irq_dispatched,
  output logic [31:0] o_irq_epc,
  output logic        o_bus_request,
  output logic [31:0] o_bus_address,
  input  logic        i_bus_ready,
  input  logic [31:0] i_bus_rdata,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_instruction,
  input  logic        i_decode_busy,
  output logic        o_fault
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, REQUEST, DISCARD} state_t;

  state_t       state;
  logic [31:0]  fetch_pc;
  logic [31:0]  bus_address;
  logic         irq_armed;
  logic         fault;
  logic         irq_dispatched;
  logic [31:0]  irq_epc;

  fetch_entry_t head;
  fetch_entry_t wr_entry;
  logic         fifo_full;
  logic         fifo_empty;
  logic         fifo_push;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;

  logic         irq_take;
  logic         flush;
  logic         done;
  logic         push;
  logic         pop;
  logic         issue;
  logic [31:0]  redirect_pc;
  logic [31:0]  next_base;
  logic [31:0]  epc_now;

  always_comb begin
    irq_take    = i_irq_pending && !i_jump && irq_armed;
    flush       = i_jump || irq_take;
    redirect_pc = word_align(i_jump ? i_jump_pc : i_irq_pc);
    done        = (state != IDLE) && i_bus_ready;
    push        = (state == REQUEST) && i_bus_ready && !flush;
    pop         = o_valid && !i_decode_busy && !flush;
    count_next  = count;
    if (flush)              count_next = '0;
    else if (push && !pop)  count_next = count + CW'(1);
    else if (pop && !push)  count_next = count - CW'(1);
    // Room is judged on post-edge occupancy, so the new request is already counted.
    issue       = ((state == IDLE) || done) && (count_next < CW'(DEPTH));
    next_base   = flush ? redirect_pc : fetch_pc;
    // Return PC is the oldest instruction not yet handed to decode.
    epc_now     = o_valid ? head.pc : ((state == REQUEST) ? bus_address : fetch_pc);
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state          <= IDLE;
      fetch_pc       <= RESET_PC;
      bus_address    <= RESET_PC;
      irq_armed      <= 1'b1;
      fault          <= 1'b0;
      irq_dispatched <= 1'b0;
      irq_epc        <= '0;
    end else begin
      if (flush && (state != IDLE) && !i_bus_ready) begin
        state    <= DISCARD;
        fetch_pc <= redirect_pc;
      end else if (issue) begin
        state       <= REQUEST;
        bus_address <= next_base;
        fetch_pc    <= next_base + 32'd4;
      end else if (done) begin
        state <= IDLE;
      end
      irq_dispatched <= irq_take;
      if (irq_take) irq_epc <= epc_now;
      if (irq_take)            irq_armed <= 1'b0;
      else if (!i_irq_pending) irq_armed <= 1'b1;
      if (i_jump && (i_jump_pc[1:0] != 2'b00)) fault <= 1'b1;
    end
  end

  assign wr_entry  = '{pc: bus_address, instruction: i_bus_rdata};
  assign fifo_push = push && (!fifo_full || pop);

  cpu_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock   (i_clock),
    .reset_n (i_reset),
    .push    (fifo_push),
    .pop     (pop),
    .flush   (flush),
    .wr_data (wr_entry),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count)
  );

  assign o_bus_request    = (state != IDLE);
  assign o_bus_address    = bus_address;
  assign o_valid          = !fifo_empty;
  assign o_pc             = head.pc;
  assign o_instruction    = head.instruction;
  assign o_irq_dispatched = irq_dispatched;
  assign o_irq_epc        = irq_epc;
  assign o_fault          = fault;

endmodule

// File: tb/tb_cpu_prefetch_queue.sv
// Self-checking bench: queue-level reference model compared every cycle, plus directed literal checks.
module tb_cpu_prefetch_queue;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_jump = 1'b0;
  logic [31:0] i_jump_pc = '0;
  logic        i_irq_pending = 1'b0;
  logic [31:0] i_irq_pc = '0;
  logic        o_irq_dispatched;
  logic [31:0] o_irq_epc;
  logic        o_bus_request;
  logic [31:0] o_bus_address;
  logic        i_bus_ready = 1'b0;
  logic [31:0] i_bus_rdata = 32'h0000_0013;
  logic        o_valid;
  logic [31:0] o_pc;
  logic [31:0] o_instruction;
  logic        i_decode_busy = 1'b0;
  logic        o_fault;

  always #5 i_clock = ~i_clock;

  cpu_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .i_clock          (i_clock),
    .i_reset          (i_reset),
    .i_jump           (i_jump),
    .i_jump_pc        (i_jump_pc),
    .i_irq_pending    (i_irq_pending),
    .i_irq_pc         (i_irq_pc),
    .o_irq_dispatched (o_irq_dispatched),
    .o_irq_epc        (o_irq_epc),
    .o_bus_request    (o_bus_request),
    .o_bus_address    (o_bus_address),
    .i_bus_ready      (i_bus_ready),
    .i_bus_rdata      (i_bus_rdata),
    .o_valid          (o_valid),
    .o_pc             (o_pc),
    .o_instruction    (o_instruction),
    .i_decode_busy    (i_decode_busy),
    .o_fault          (o_fault)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: queue of delivered words, one outstanding bus transaction, irq/fault flags.
  typedef struct { logic [31:0] pc; logic [31:0] ins; } ment_t;
  ment_t       mq[$];
  bit          m_out, m_stale, m_armed, m_fault, m_disp;
  logic [31:0] m_addr, m_next_pc, m_epc;
  bit          cmp_en = 1'b0;

  task automatic model_reset();
    mq.delete();
    m_out = 0; m_stale = 0; m_armed = 1; m_fault = 0; m_disp = 0;
    m_addr = RST_PC; m_next_pc = RST_PC; m_epc = '0;
  endtask

  task automatic model_update();
    bit take, flush, popok;
    logic [31:0] tgt;
    ment_t e;
    if (!i_reset) model_reset();
    else begin
      take  = i_irq_pending && !i_jump && m_armed;
      flush = i_jump || take;
      tgt   = i_jump ? i_jump_pc : i_irq_pc;
      tgt   = tgt & 32'hFFFF_FFFC;
      if (i_jump && (i_jump_pc[1:0] != 2'b00)) m_fault = 1;
      m_disp = take;
      if (take) m_epc = (mq.size() > 0) ? mq[0].pc : ((m_out && !m_stale) ? m_addr : m_next_pc);
      if (take) m_armed = 0;
      else if (!i_irq_pending) m_armed = 1;
      popok = (mq.size() > 0) && !i_decode_busy && !flush;
      if (popok) void'(mq.pop_front());
      if (m_out && i_bus_ready && !m_stale && !flush) begin
        e.pc = m_addr; e.ins = i_bus_rdata;
        mq.push_back(e);
      end
      if (flush) begin
        mq.delete();
        m_next_pc = tgt;
      end
      if (m_out && !i_bus_ready) m_stale = m_stale || flush;
      else begin
        m_out = 0;
        if (mq.size() < DEPTH) begin
          m_out = 1; m_stale = 0; m_addr = m_next_pc; m_next_pc = m_next_pc + 32'd4;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("bus_request", o_bus_request, m_out);
    if (m_out) check("bus_address", o_bus_address, m_addr);
    check("valid", o_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      check("pc", o_pc, mq[0].pc);
      check("instruction", o_instruction, mq[0].ins);
    end
    check("irq_dispatched", o_irq_dispatched, m_disp);
    check("irq_epc", o_irq_epc, m_epc);
    check("fault", o_fault, m_fault);
  endtask

  always @(posedge i_clock) model_update();
  always @(negedge i_clock) if (cmp_en) compare_all();

  task automatic do_reset();
    @(negedge i_clock);
    #2 i_reset = 1'b0;
    model_reset();
    #1;
    check("reset_drops_request", o_bus_request, 1'b0);
    @(negedge i_clock);
    i_reset = 1'b1;
  endtask

  int nreq;
  bit found;

  initial begin
    model_reset();
    cmp_en = 1'b1;
    repeat (2) @(negedge i_clock);
    check("reset_request", o_bus_request, 1'b0);
    check("reset_valid", o_valid, 1'b0);
    check("reset_fault", o_fault, 1'b0);

    // Zero-wait bus after reset release
    i_reset = 1'b1; i_bus_ready = 1'b1;
    @(negedge i_clock);
    check("first_req", o_bus_request, 1'b1);
    check("first_addr", o_bus_address, 32'h0);
    check("first_valid", o_valid, 1'b0);
    @(negedge i_clock);
    check("cycle2_valid", o_valid, 1'b1);
    check("cycle2_pc", o_pc, 32'h0);
    check("cycle2_ins", o_instruction, 32'h0000_0013);
    check("cycle2_addr", o_bus_address, 32'h4);
    @(negedge i_clock);
    check("cycle3_pc", o_pc, 32'h4);

    // Decode stalled: queue fills with exactly DEPTH requests
    i_decode_busy = 1'b1;
    do_reset();
    nreq = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge i_clock);
      if (o_bus_request) nreq++;
    end
    check("full_request_count", nreq, 4);
    check("full_no_request", o_bus_request, 1'b0);
    i_decode_busy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("drain_pc", o_pc, 32'(4 * k));
      @(negedge i_clock);
    end

    // Jump while 0x8 outstanding with wait states
    do_reset();
    repeat (3) @(negedge i_clock);
    check("wait_addr", o_bus_address, 32'h8);
    i_bus_ready = 1'b0;
    repeat (2) @(negedge i_clock);
    i_jump = 1'b1; i_jump_pc = 32'h100;
    @(negedge i_clock);
    i_jump = 1'b0;
    check("stale_held_addr", o_bus_address, 32'h8);
    check("stale_held_req", o_bus_request, 1'b1);
    i_bus_ready = 1'b1;
    @(negedge i_clock);
    check("redirect_addr", o_bus_address, 32'h100);
    check("stale_dropped", o_valid, 1'b0);
    @(negedge i_clock);
    check("redirect_pc", o_pc, 32'h100);

    // Interrupt with head at 0x40
    i_decode_busy = 1'b1; i_jump = 1'b1; i_jump_pc = 32'h40;
    @(negedge i_clock);
    i_jump = 1'b0;
    @(negedge i_clock);
    check("irq_head_pc", o_pc, 32'h40);
    i_irq_pending = 1'b1; i_irq_pc = 32'h200;
    @(negedge i_clock);
    check("irq_pulse", o_irq_dispatched, 1'b1);
    check("irq_epc", o_irq_epc, 32'h40);
    i_irq_pending = 1'b0;
    @(negedge i_clock);
    check("irq_pulse_end", o_irq_dispatched, 1'b0);
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (o_valid) found = 1;
      else @(negedge i_clock);
    end
    check("irq_target_valid", found, 1'b1);
    check("irq_target_pc", o_pc, 32'h200);

    // Jump and interrupt together
    i_jump = 1'b1; i_jump_pc = 32'h300; i_irq_pending = 1'b1;
    @(negedge i_clock);
    i_jump = 1'b0;
    check("jump_wins", o_irq_dispatched, 1'b0);
    @(negedge i_clock);
    check("irq_after_jump", o_irq_dispatched, 1'b1);
    check("irq_after_jump_epc", o_irq_epc, 32'h300);
    i_irq_pending = 1'b0;

    // Misaligned jump, address wrap, reset mid-request
    @(negedge i_clock);
    i_jump = 1'b1; i_jump_pc = 32'h102;
    @(negedge i_clock);
    i_jump = 1'b0;
    check("fault_set", o_fault, 1'b1);
    check("fault_addr", o_bus_address, 32'h100);
    i_jump = 1'b1; i_jump_pc = 32'hFFFF_FFFC;
    @(negedge i_clock);
    i_jump = 1'b0;
    check("top_addr", o_bus_address, 32'hFFFF_FFFC);
    @(negedge i_clock);
    check("wrap_addr", o_bus_address, 32'h0);
    check("fault_sticky", o_fault, 1'b1);
    i_bus_ready = 1'b0;
    @(negedge i_clock);
    check("pre_reset_req", o_bus_request, 1'b1);
    i_bus_ready = 1'b1;
    do_reset();
    check("fault_cleared", o_fault, 1'b0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge i_clock);
      i_bus_ready   = ($urandom_range(0, 9) < 6);
      i_bus_rdata   = $urandom;
      i_decode_busy = ($urandom_range(0, 9) < 4);
      i_jump        = ($urandom_range(0, 19) == 0);
      i_jump_pc     = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                 : ($urandom & 32'h0000_FFFC);
      if ($urandom_range(0, 31) == 0) i_jump_pc = i_jump_pc | 32'h1;
      if ($urandom_range(0, 7) == 0) i_irq_pending = !i_irq_pending;
      i_irq_pc      = $urandom;
      if ($urandom_range(0, 499) == 0) begin
        #2 i_reset = 1'b0;
        model_reset();
        @(negedge i_clock);
        i_reset = 1'b1;
      end
    end

    @(negedge i_clock);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
